// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter.
//   uart_tx_state_e : transmitter FSM states
//   uart_parity_e   : parity-mode encoding of the 2-bit parity_mode input
//   parity_enabled  : true when a mode appends a parity bit (reserved = none)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_RSVD
  } uart_parity_e;

  function automatic logic parity_enabled(input uart_parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts clk cycles within one serial bit period.
//   clk, srst : clock and synchronous active-high reset
//   en        : count while a frame is in progress
//   clr       : restart the bit period at 0 (frame start)
//   bit_end   : high on the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  logic [DIV_W-1:0] cnt_reg;

  assign bit_end = en && (cnt_reg == DIV_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= bit_end ? '0 : cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register.
//   tx_clk, tx_rst   : clock, synchronous active-high reset
//   tx_i_data        : word to send (LSB first)
//   tx_i_data_valid  : producer has a word; accepted on valid & ready
//   tx_i_parity_mode : 0 none, 1 even, 2 odd, 3 treated as none
//   tx_i_stop2       : two stop bits when set
//   tx_o_ready       : holding register empty
//   tx_o             : registered serial line, idle high
//   tx_o_busy        : frame in progress
//   tx_o_done        : pulse on the final cycle of the last stop bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter  int DATA_BITS    = 8,
  parameter  int CLKS_PER_BIT = 16,
  localparam int DIV_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic [DATA_BITS-1:0] tx_i_data,
  input  logic                 tx_i_data_valid,
  input  logic [1:0]           tx_i_parity_mode,
  input  logic                 tx_i_stop2,
  output logic                 tx_o_ready,
  output logic                 tx_o,
  output logic                 tx_o_busy,
  output logic                 tx_o_done
);

  localparam int BIT_W = $clog2(DATA_BITS);

  uart_tx_state_e       state_reg, state_next;
  logic [DATA_BITS-1:0] hold_data_reg, shift_reg;
  uart_parity_e         hold_mode_reg;
  logic                 hold_stop2_reg, hold_full_reg, hold_full_next, ready_reg;
  logic                 par_en_reg, par_bit_reg, stop2_reg, tx_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic                 bit_end, accept, load, shift, bit_clr, bit_inc, tx_next;

  assign accept         = tx_i_data_valid && ready_reg;
  // Accept and load are mutually exclusive: accept needs hold empty, load needs it full.
  assign hold_full_next = accept || (hold_full_reg && !load);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DIV_W        (DIV_W)
  ) baud (
    .clk     (tx_clk),
    .srst    (tx_rst),
    .en      (state_reg != IDLE),
    .clr     (load),
    .bit_end (bit_end)
  );

  always_ff @(posedge tx_clk) begin
    if (tx_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // tx_next is the line value for the state being entered, so the serial
  // output is registered yet aligned with the FSM state.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift      = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    tx_next    = 1'b1;
    tx_o_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          state_next = START;
          load       = 1'b1;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          bit_clr    = 1'b1;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_end) begin
          shift = 1'b1;
          if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
            bit_clr = 1'b1;
            if (par_en_reg) begin
              state_next = PARITY;
              tx_next    = par_bit_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_inc = 1'b1;
            tx_next = shift_reg[1];
          end
        end
      end
      PARITY: begin
        tx_next = par_bit_reg;
        if (bit_end) begin
          state_next = STOP;
          bit_clr    = 1'b1;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_reg == BIT_W'(stop2_reg)) begin
            tx_o_done = 1'b1;
            bit_clr   = 1'b1;
            // A waiting word starts immediately: no idle bit between frames.
            if (hold_full_reg) begin
              state_next = START;
              load       = 1'b1;
              tx_next    = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      hold_data_reg  <= '0;
      hold_mode_reg  <= PAR_NONE;
      hold_stop2_reg <= 1'b0;
      hold_full_reg  <= 1'b0;
      ready_reg      <= 1'b0;
      shift_reg      <= '0;
      par_en_reg     <= 1'b0;
      par_bit_reg    <= 1'b0;
      stop2_reg      <= 1'b0;
      bit_cnt_reg    <= '0;
      tx_reg         <= 1'b1;
    end else begin
      tx_reg        <= tx_next;
      hold_full_reg <= hold_full_next;
      ready_reg     <= !hold_full_next;
      if (accept) begin
        hold_data_reg  <= tx_i_data;
        hold_mode_reg  <= uart_parity_e'(tx_i_parity_mode);
        hold_stop2_reg <= tx_i_stop2;
      end
      // Frame config is latched with the data, so later input changes
      // cannot disturb a frame in flight.
      if (load) begin
        shift_reg   <= hold_data_reg;
        par_en_reg  <= parity_enabled(hold_mode_reg);
        par_bit_reg <= (hold_mode_reg == PAR_ODD) ? ~^hold_data_reg : ^hold_data_reg;
        stop2_reg   <= hold_stop2_reg;
      end else if (shift) begin
        shift_reg <= shift_reg >> 1;
      end
      if (bit_clr)      bit_cnt_reg <= '0;
      else if (bit_inc) bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
    end
  end

  assign tx_o       = tx_reg;
  assign tx_o_ready = ready_reg;
  assign tx_o_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  // 8-bit instance
  logic       tx_rst = 1'b1;
  logic [7:0] tx_i_data = '0;
  logic       tx_i_data_valid = 1'b0;
  logic [1:0] tx_i_parity_mode = '0;
  logic       tx_i_stop2 = 1'b0;
  logic       tx_o_ready, tx_o, tx_o_busy, tx_o_done;

  // 7-bit instance
  logic       rst7 = 1'b1;
  logic [6:0] d7 = '0;
  logic       v7 = 1'b0;
  logic [1:0] m7 = '0;
  logic       s27 = 1'b0;
  logic       rdy7, tx7, busy7, done7;
  logic       d7_fin = 1'b0;

  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .tx_i_data(tx_i_data),
    .tx_i_data_valid(tx_i_data_valid), .tx_i_parity_mode(tx_i_parity_mode),
    .tx_i_stop2(tx_i_stop2), .tx_o_ready(tx_o_ready), .tx_o(tx_o),
    .tx_o_busy(tx_o_busy), .tx_o_done(tx_o_done)
  );

  uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(CPB)) dut7 (
    .tx_clk(tx_clk), .tx_rst(rst7), .tx_i_data(d7),
    .tx_i_data_valid(v7), .tx_i_parity_mode(m7),
    .tx_i_stop2(s27), .tx_o_ready(rdy7), .tx_o(tx7),
    .tx_o_busy(busy7), .tx_o_done(done7)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge tx_clk) begin
    cyc   <= cyc + 1;
    rst_q <= tx_rst;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       s2;
    int         acc;   // posedge index at which the word was accepted
  } frame_t;
  frame_t exp_q[$];
  int sent_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference frame: start 0, nd data bits LSB first, optional parity, stop 1s.
  function automatic int nbits(int nd, logic [1:0] mode, logic s2);
    return 1 + nd + ((mode == 2'd1 || mode == 2'd2) ? 1 : 0) + (s2 ? 2 : 1);
  endfunction

  function automatic logic exp_bit(logic [8:0] data, int nd, logic [1:0] mode, int idx);
    logic odd_ones;
    odd_ones = ($countones(data) % 2) == 1;
    if (idx == 0) return 1'b0;
    if (idx <= nd) return data[idx-1];
    if (idx == nd + 1 && mode == 2'd1) return odd_ones;
    if (idx == nd + 1 && mode == 2'd2) return !odd_ones;
    return 1'b1;
  endfunction

  task automatic tick;
    @(posedge tx_clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard for the 8-bit instance ----------------
  frame_t cur;
  logic   in_frame = 1'b0, rst_seen = 1'b0;
  int     pos = 0, len = 0, last_end = -1000, done_cnt = 0, frames_done = 0;

  always @(negedge tx_clk) begin
    if (cyc > 0) begin
      if (rst_q) begin
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", tx_o_busy, 0);
        chk("rst_ready", tx_o_ready, 0);
        chk("rst_done", tx_o_done, 0);
        in_frame = 1'b0;
        exp_q.delete();
        last_end = -1000;
        rst_seen = 1'b1;
      end else begin
        if (rst_seen) chk("ready_after_rst", tx_o_ready, 1);
        rst_seen = 1'b0;
        if (tx_o_done === 1'b1) done_cnt++;
        if (in_frame) begin
          pos++;
        end else if (tx_o === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("start_with_empty_queue", 1, 0);
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            pos      = 1;
            len      = nbits(8, cur.mode, cur.s2) * CPB;
            chk("start_cycle", cyc, (cur.acc + 1 > last_end + 1) ? cur.acc + 1 : last_end + 1);
            chk("ready_after_load", tx_o_ready, 1);
          end
        end else begin
          chk("idle_busy", tx_o_busy, 0);
          chk("idle_done", tx_o_done, 0);
        end
        if (in_frame) begin
          chk("tx_bit", tx_o, exp_bit({1'b0, cur.data}, 8, cur.mode, (pos - 1) / CPB));
          chk("busy", tx_o_busy, 1);
          chk("done", tx_o_done, (pos == len) ? 1 : 0);
          if (pos == len) begin
            $display("frame data=%02h mode=%0d stop2=%0d len=%0d end_cycle=%0d",
                     cur.data, cur.mode, cur.s2, len, cyc);
            in_frame = 1'b0;
            last_end = cyc;
            frames_done++;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s);
    int w;
    frame_t f;
    tx_i_data        = d;
    tx_i_parity_mode = m;
    tx_i_stop2       = s;
    tx_i_data_valid  = 1'b1;
    w = 0;
    while (tx_o_ready !== 1'b1 && w < 3000) begin
      tick;
      w++;
    end
    if (tx_o_ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      tx_i_data_valid = 1'b0;
      return;
    end
    f.data = d; f.mode = m; f.s2 = s; f.acc = cyc + 1;
    exp_q.push_back(f);
    sent_cnt++;
    tick;
    chk("ready_drop_after_accept", tx_o_ready, 0);
  endtask

  task automatic wait_idle;
    int w;
    w = 0;
    while ((in_frame || exp_q.size() != 0 || tx_o_busy !== 1'b0) && w < 3000) begin
      tick;
      w++;
    end
    chk("idle_timeout", (w < 3000) ? 1 : 0, 1);
  endtask

  // ---------------- stimulus for the 8-bit instance ----------------
  initial begin
    int w;
    repeat (3) tick;
    tx_rst = 1'b0;
    tick;
    // 8N1 0xA5
    send(8'hA5, 2'd0, 1'b0);
    tx_i_data_valid = 1'b0;
    wait_idle;
    // parity modes on 0x07, valid held so frames also run back-to-back
    send(8'h07, 2'd1, 1'b0);
    send(8'h07, 2'd2, 1'b0);
    send(8'h07, 2'd3, 1'b0);
    tx_i_data_valid = 1'b0;
    wait_idle;
    // two stop bits
    send(8'h00, 2'd0, 1'b1);
    tx_i_data_valid = 1'b0;
    wait_idle;
    // back-to-back pair
    send(8'h11, 2'd0, 1'b0);
    send(8'h22, 2'd0, 1'b0);
    tx_i_data_valid = 1'b0;
    wait_idle;
    // reset in the middle of DATA with a second word waiting in hold
    send(8'h3C, 2'd0, 1'b0);
    send(8'h5A, 2'd1, 1'b1);
    tx_i_data_valid = 1'b0;
    repeat (12) tick;
    chk("busy_before_rst", tx_o_busy, 1);
    tx_rst = 1'b1;
    tick;
    tick;
    tx_rst = 1'b0;
    repeat (4) tick;
    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      send(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        tx_i_data_valid = 1'b0;
        repeat ($urandom_range(1, 50)) tick;
      end
    end
    tx_i_data_valid = 1'b0;
    wait_idle;
    repeat (5) tick;
    chk("queue_empty", exp_q.size(), 0);
    chk("frames_completed", frames_done, sent_cnt - 2);
    chk("done_pulses", done_cnt, sent_cnt - 2);
    w = 0;
    while (!d7_fin && w < 5000) begin
      tick;
      w++;
    end
    chk("d7_finished", d7_fin, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- 7-bit instance: directed frame walk ----------------
  initial begin
    int w, nb;
    logic [6:0] d;
    logic [1:0] m;
    logic s;
    repeat (3) tick;
    rst7 = 1'b0;
    tick;
    chk("d7_ready_after_rst", rdy7, 1);
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 7'h7F : 7'($urandom);
      m = (k == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      s = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      d7 = d; m7 = m; s27 = s; v7 = 1'b1;
      w = 0;
      while (rdy7 !== 1'b1 && w < 200) begin
        tick;
        w++;
      end
      tick;
      v7 = 1'b0;
      w = 0;
      while (tx7 !== 1'b0 && w < 20) begin
        tick;
        w++;
      end
      chk("d7_latency", w, 1);
      nb = nbits(7, m, s);
      for (int j = 0; j < nb; j++) begin
        chk("d7_bit", tx7, exp_bit({2'b00, d}, 7, m, j));
        chk("d7_busy", busy7, 1);
        chk("d7_done_early", done7, 0);
        if (j < nb - 1) begin
          repeat (CPB) tick;
        end else begin
          repeat (CPB - 1) tick;
          chk("d7_done", done7, 1);
          chk("d7_stop", tx7, 1);
        end
      end
      tick;
      chk("d7_idle_busy", busy7, 0);
      chk("d7_idle_done", done7, 0);
      $display("d7 frame data=%02h mode=%0d stop2=%0d bits=%0d", d, m, s, nb);
    end
    d7_fin = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
